// File: rtl/led_pkg.sv
// Shared rate codes, reset-default rates and rate/period helpers for the LED
// blink scheduler and its per-LED channels.
package led_pkg;

  localparam logic [2:0] RATE_OFF  = 3'd0;
  localparam logic [2:0] RATE_1HZ  = 3'd1;
  localparam logic [2:0] RATE_2HZ  = 3'd2;
  localparam logic [2:0] RATE_5HZ  = 3'd3;
  localparam logic [2:0] RATE_10HZ = 3'd4;
  localparam logic [2:0] RATE_ON   = 3'd5;
  localparam logic [2:0] RATE_LAST = 3'd5;

  localparam int NUM_LEDS = 4;

  typedef enum logic {
    PAUSE_RUN  = 1'b0,
    PAUSE_HOLD = 1'b1
  } pause_state_e;

  function automatic logic [2:0] default_rate(input logic [1:0] idx);
    logic [2:0] r;
    case (idx)
      2'd0:    r = RATE_10HZ;
      2'd1:    r = RATE_5HZ;
      2'd2:    r = RATE_2HZ;
      default: r = RATE_1HZ;
    endcase
    return r;
  endfunction

  // Toggle period in base ticks; non-blinking codes never consult it.
  function automatic logic [3:0] rate_period(input logic [2:0] rate);
    logic [3:0] p;
    case (rate)
      RATE_1HZ:  p = 4'd10;
      RATE_2HZ:  p = 4'd5;
      RATE_5HZ:  p = 4'd2;
      RATE_10HZ: p = 4'd1;
      default:   p = 4'd1;
    endcase
    return p;
  endfunction

  function automatic logic [2:0] next_rate(input logic [2:0] rate);
    return (rate >= RATE_LAST) ? RATE_OFF : rate + 3'd1;
  endfunction

endpackage

// File: rtl/led_rate_channel.sv
// One LED channel: holds its rate code, a tick counter and the LED flop, and
// toggles the LED every rate_period ticks.
module led_rate_channel
  import led_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [2:0] rate_in,
  input  logic       load,
  input  logic [2:0] reset_rate,
  output logic [2:0] rate_out,
  output logic       led
);

  logic [2:0] rate_q, rate_d;
  logic [3:0] cnt_q, cnt_d;
  logic       led_q, led_d;

  always_comb begin
    rate_d = rate_q;
    cnt_d  = cnt_q;
    led_d  = led_q;
    if (load) begin
      // A load beats a coincident tick: restart the phase with the LED dark
      // unless the new rate is steady-on.
      rate_d = rate_in;
      cnt_d  = 4'd0;
      led_d  = (rate_in == RATE_ON);
    end else begin
      case (rate_q)
        RATE_1HZ, RATE_2HZ, RATE_5HZ, RATE_10HZ: begin
          if (tick) begin
            if (cnt_q == rate_period(rate_q) - 4'd1) begin
              cnt_d = 4'd0;
              led_d = ~led_q;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        RATE_ON: begin
          cnt_d = 4'd0;
          led_d = 1'b1;
        end
        default: begin
          cnt_d = 4'd0;
          led_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rate_q <= reset_rate;
      cnt_q  <= 4'd0;
      led_q  <= 1'b0;
    end else begin
      rate_q <= rate_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
    end
  end

  assign rate_out = rate_q;
  assign led      = led_q;

endmodule

// File: rtl/led_blink_scheduler.sv
// Four-LED blink scheduler: shared prescaler and pause FSM feed per-LED rate
// channels; button pulses pick an LED and cycle its rate.
module led_blink_scheduler
  import led_pkg::*;
#(
  parameter int g_CLKS_PER_TICK = 1250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Sel_Pulse,
  input  logic       i_Rate_Pulse,
  input  logic       i_Pause,
  output logic [1:0] o_Sel_LED,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4
);

  localparam int PW = (g_CLKS_PER_TICK > 1) ? $clog2(g_CLKS_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(g_CLKS_PER_TICK - 1);

  pause_state_e          pause_state_q, pause_state_d;
  logic                  run_en;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  tick;
  logic [1:0]            sel_q, sel_d;
  logic [NUM_LEDS-1:0]   load;
  logic [2:0]            rate_cur [NUM_LEDS];
  logic [2:0]            rate_new;
  logic [NUM_LEDS-1:0]   led;

  // The pause level gates the prescaler in the very cycle it is seen, so no
  // tick can slip through while the state register catches up.
  always_comb begin
    pause_state_d = pause_state_q;
    run_en        = 1'b0;
    case (pause_state_q)
      PAUSE_RUN: begin
        run_en = !i_Pause;
        if (i_Pause) pause_state_d = PAUSE_HOLD;
      end
      PAUSE_HOLD: begin
        run_en = !i_Pause;
        if (!i_Pause) pause_state_d = PAUSE_RUN;
      end
    endcase
  end

  always_comb begin
    presc_d  = presc_q;
    tick     = run_en && (presc_q == PRESC_LAST);
    sel_d    = sel_q;
    load     = '0;
    rate_new = next_rate(rate_cur[sel_q]);
    if (run_en) presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    if (i_Rate_Pulse) load[sel_q] = 1'b1;
    if (i_Sel_Pulse) sel_d = sel_q + 2'd1;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      pause_state_q <= PAUSE_RUN;
      presc_q       <= '0;
      sel_q         <= 2'd0;
    end else begin
      pause_state_q <= pause_state_d;
      presc_q       <= presc_d;
      sel_q         <= sel_d;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    led_rate_channel u_chan (
      .clk        (i_Clk),
      .rst_n      (i_Rst_L),
      .tick       (tick),
      .rate_in    (rate_new),
      .load       (load[i]),
      .reset_rate (default_rate(2'(i))),
      .rate_out   (rate_cur[i]),
      .led        (led[i])
    );
  end

  assign o_Sel_LED = sel_q;
  assign o_LED_1   = led[0];
  assign o_LED_2   = led[1];
  assign o_LED_3   = led[2];
  assign o_LED_4   = led[3];

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler: directed scenarios plus random pulses/pauses,
// checked every cycle against a tick-count reference model.
module tb_led_blink_scheduler;

  localparam int N = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel_p = 1'b0;
  logic rate_p = 1'b0;
  logic pause = 1'b0;
  logic [1:0] sel_led;
  logic led1, led2, led3, led4;

  always #5 clk = ~clk;

  led_blink_scheduler #(.g_CLKS_PER_TICK(N)) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Sel_Pulse  (sel_p),
    .i_Rate_Pulse (rate_p),
    .i_Pause      (pause),
    .o_Sel_LED    (sel_led),
    .o_LED_1      (led1),
    .o_LED_2      (led2),
    .o_LED_3      (led3),
    .o_LED_4      (led4)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: LED state derived from ticks elapsed since the channel
  // was last (re)loaded, not from per-channel counters.
  int m_presc, m_total, m_sel;
  int m_rate [4];
  int m_base [4];
  logic [5:0] exp_q [$];

  function automatic int period_of(input int r);
    case (r)
      1: return 10;
      2: return 5;
      3: return 2;
      4: return 1;
      default: return 1;
    endcase
  endfunction

  function automatic logic model_led(input int ch);
    int r;
    r = m_rate[ch];
    if (r == 5) return 1'b1;
    if (r < 1 || r > 4) return 1'b0;
    return (((m_total - m_base[ch]) / period_of(r)) % 2) == 1;
  endfunction

  task automatic model_reset();
    m_presc = 0;
    m_total = 0;
    m_sel   = 0;
    m_rate[0] = 4; m_rate[1] = 3; m_rate[2] = 2; m_rate[3] = 1;
    for (int c = 0; c < 4; c++) m_base[c] = 0;
  endtask

  task automatic model_edge();
    logic [3:0] e;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!pause) begin
        if (m_presc == N - 1) m_total++;
        m_presc = (m_presc + 1) % N;
      end
      if (rate_p) begin
        m_rate[m_sel] = (m_rate[m_sel] == 5) ? 0 : m_rate[m_sel] + 1;
        m_base[m_sel] = m_total;
      end
      if (sel_p) m_sel = (m_sel + 1) % 4;
    end
    for (int c = 0; c < 4; c++) e[c] = model_led(c);
    exp_q.push_back({2'(m_sel), e});
  endtask

  // checker
  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // driver: one clock, model update, compare, clear pulses
  task automatic step();
    logic [5:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    check("sel", {6'd0, sel_led}, {6'd0, e[5:4]});
    check("leds", {4'd0, led4, led3, led2, led1}, {4'd0, e[3:0]});
    sel_p  = 1'b0;
    rate_p = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    #1;
    // reset state
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(100);

    // sel 0: ON, OFF, 1 Hz
    rate_p = 1'b1; step(); idle(20);
    rate_p = 1'b1; step(); idle(20);
    rate_p = 1'b1; step(); idle(90);

    // select LED_4 and move it to 2 Hz
    sel_p = 1'b1; step();
    sel_p = 1'b1; step();
    sel_p = 1'b1; step();
    rate_p = 1'b1; step(); idle(60);

    // back to sel 1, then simultaneous select + rate
    sel_p = 1'b1; step();
    sel_p = 1'b1; step();
    sel_p = 1'b1; rate_p = 1'b1; step(); idle(30);

    // pause mid-blink with a rate pulse inside the pause
    idle(5);
    pause = 1'b1;
    idle(10);
    rate_p = 1'b1; step();
    idle(19);
    pause = 1'b0;
    idle(60);

    // one-cycle reset coinciding with a rate pulse
    rst_n = 1'b0; rate_p = 1'b1; step();
    rst_n = 1'b1;
    idle(60);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      sel_p  = ($urandom_range(0, 15) == 0);
      rate_p = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 59) == 0) pause = ~pause;
      rst_n  = ($urandom_range(0, 799) != 0);
      step();
    end
    pause = 1'b0;
    rst_n = 1'b1;
    idle(50);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
